// File: rtl/urv_timer_mc.sv
// rtl/urv_timer_mc.sv - multi-channel system timer: cycle counter, prescaled tick counter, compare channels
module urv_timer_mc #(
  parameter int G_NUM_CH    = 4,
  parameter int G_TIME_W    = 32,
  parameter int G_CYCLES_W  = 64,
  parameter int G_CLK_FREQ  = 62500000,
  parameter int G_TICK_FREQ = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [5:0]            wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  rd_en_i,
  input  logic [5:0]            rd_addr_i,
  output logic [31:0]           rd_data_o,
  output logic [G_TIME_W-1:0]   csr_time_o,
  output logic [G_CYCLES_W-1:0] csr_cycles_o,
  output logic                  sys_tick_o,
  output logic [G_NUM_CH-1:0]   irq_o
);

  localparam logic [23:0] PRESC_RST = 24'(G_CLK_FREQ / G_TICK_FREQ - 1);

  logic [23:0]         presc;
  logic [23:0]         presc_cnt;
  logic                en;
  logic [G_TIME_W-1:0] cmp    [G_NUM_CH];
  logic [G_TIME_W-1:0] period [G_NUM_CH];
  logic [G_NUM_CH-1:0] ch_en;
  logic [G_NUM_CH-1:0] ch_per;

  logic                wr_presc, wr_ctrl, wr_pend, wr_time;
  logic [G_NUM_CH-1:0] wr_cmp, wr_period, wr_chctrl;
  logic [G_NUM_CH-1:0] hit;
  logic [G_NUM_CH-1:0] rearm;
  logic [G_TIME_W-1:0] time_inc;
  logic [31:0]         rd_mux;

  assign time_inc = csr_time_o + G_TIME_W'(1);

  // Write address decode; channel c owns words 4+4c .. 7+4c, the last one reserved
  always_comb begin
    wr_presc = wr_en_i && (wr_addr_i == 6'd0);
    wr_ctrl  = wr_en_i && (wr_addr_i == 6'd1);
    wr_pend  = wr_en_i && (wr_addr_i == 6'd2);
    wr_time  = wr_en_i && (wr_addr_i == 6'd3);
    for (int c = 0; c < G_NUM_CH; c++) begin
      wr_cmp[c]    = wr_en_i && (wr_addr_i == 6'(4 + 4 * c));
      wr_period[c] = wr_en_i && (wr_addr_i == 6'(5 + 4 * c));
      wr_chctrl[c] = wr_en_i && (wr_addr_i == 6'(6 + 4 * c));
    end
  end

  // Compare against the value time is about to take, so pend and time==CMP land together.
  // A TIME write overrides the increment and must not produce a hit.
  always_comb begin
    for (int c = 0; c < G_NUM_CH; c++) begin
      hit[c]   = ch_en[c] && sys_tick_o && !wr_time && (time_inc == cmp[c]);
      rearm[c] = ch_per[c] && (period[c] != '0);
    end
  end

  // Prescaler: a PRESC write restarts the period and suppresses the tick of that cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      presc_cnt  <= '0;
      sys_tick_o <= 1'b0;
    end else if (wr_presc) begin
      presc_cnt  <= '0;
      sys_tick_o <= 1'b0;
    end else if (en) begin
      if (presc_cnt == presc) begin
        presc_cnt  <= '0;
        sys_tick_o <= 1'b1;
      end else begin
        presc_cnt  <= presc_cnt + 24'd1;
        sys_tick_o <= 1'b0;
      end
    end else begin
      sys_tick_o <= 1'b0;
    end
  end

  // Global configuration, tick counter and free-running cycle counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      presc        <= PRESC_RST;
      en           <= 1'b1;
      csr_time_o   <= '0;
      csr_cycles_o <= '0;
    end else begin
      csr_cycles_o <= csr_cycles_o + G_CYCLES_W'(1);
      if (wr_presc) presc <= wr_data_i[23:0];
      if (wr_ctrl)  en    <= wr_data_i[0];
      if (wr_time) begin
        csr_time_o <= wr_data_i[G_TIME_W-1:0];
      end else if (sys_tick_o) begin
        csr_time_o <= time_inc;
      end
    end
  end

  // Compare channels: register writes beat the hit-driven update, pend set beats W1C
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < G_NUM_CH; c++) begin
        cmp[c]    <= '0;
        period[c] <= '0;
      end
      ch_en  <= '0;
      ch_per <= '0;
      irq_o  <= '0;
    end else begin
      for (int c = 0; c < G_NUM_CH; c++) begin
        irq_o[c] <= (irq_o[c] && !(wr_pend && wr_data_i[c])) || hit[c];
        if (wr_cmp[c]) begin
          cmp[c] <= wr_data_i[G_TIME_W-1:0];
        end else if (hit[c] && rearm[c]) begin
          cmp[c] <= cmp[c] + period[c];
        end
        if (wr_period[c]) period[c] <= wr_data_i[G_TIME_W-1:0];
        if (wr_chctrl[c]) begin
          ch_en[c]  <= wr_data_i[0];
          ch_per[c] <= wr_data_i[1];
        end else if (hit[c] && !rearm[c]) begin
          ch_en[c] <= 1'b0;
        end
      end
    end
  end

  // Read mux over current register state; a same-cycle write is therefore not yet visible
  always_comb begin
    rd_mux = '0;
    case (rd_addr_i)
      6'd0:    rd_mux = {8'd0, presc};
      6'd1:    rd_mux = {31'd0, en};
      6'd2:    rd_mux = 32'(irq_o);
      6'd3:    rd_mux = 32'(csr_time_o);
      default: rd_mux = '0;
    endcase
    for (int c = 0; c < G_NUM_CH; c++) begin
      if (rd_addr_i == 6'(4 + 4 * c)) rd_mux = 32'(cmp[c]);
      if (rd_addr_i == 6'(5 + 4 * c)) rd_mux = 32'(period[c]);
      if (rd_addr_i == 6'(6 + 4 * c)) rd_mux = {30'd0, ch_per[c], ch_en[c]};
    end
  end

  // Read data register: loads on a read strobe, otherwise holds
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_urv_timer_mc.sv
// tb/tb_urv_timer_mc.sv - scoreboard bench for urv_timer_mc
module tb_urv_timer_mc;

  localparam int NCH = 4;
  localparam int TW  = 8;
  localparam int CW  = 64;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic           wr_en_i = 1'b0;
  logic [5:0]     wr_addr_i = '0;
  logic [31:0]    wr_data_i = '0;
  logic           rd_en_i = 1'b0;
  logic [5:0]     rd_addr_i = '0;
  logic [31:0]    rd_data_o;
  logic [TW-1:0]  csr_time_o;
  logic [CW-1:0]  csr_cycles_o;
  logic           sys_tick_o;
  logic [NCH-1:0] irq_o;

  urv_timer_mc #(
    .G_NUM_CH(NCH), .G_TIME_W(TW), .G_CYCLES_W(CW), .G_CLK_FREQ(1000), .G_TICK_FREQ(100)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .csr_time_o(csr_time_o), .csr_cycles_o(csr_cycles_o),
    .sys_tick_o(sys_tick_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t rdq[$];
  chk_t sigq[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic rd_vld = 1'b0;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] probe(input int sel);
    case (sel)
      0:       return 64'(irq_o);
      1:       return 64'(sys_tick_o);
      2:       return 64'(csr_time_o);
      3:       return csr_cycles_o;
      default: return 64'(rd_data_o);
    endcase
  endfunction

  // read response is valid the cycle after the strobe
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_vld <= 1'b0;
    else        rd_vld <= rd_en_i;
  end

  // monitor: pops expectations and compares away from the active edge
  always @(negedge clk_i) begin : monitor
    chk_t e;
    if (rd_vld) begin
      if (rdq.size() == 0) begin
        compare("rdq_underflow", 64'd1, 64'd0);
      end else begin
        e = rdq.pop_front();
        compare(e.name, 64'(rd_data_o), e.exp);
      end
    end
    while (sigq.size() > 0) begin
      e = sigq.pop_front();
      compare(e.name, probe(e.sel), e.exp);
    end
  end

  task automatic expect_sig(input int sel, input logic [63:0] exp, input string name);
    chk_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    sigq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    step(1);
    wr_en_i = 1'b0;
  endtask

  task automatic reg_rd(input logic [5:0] a, input logic [31:0] exp, input string name);
    chk_t e;
    e.sel = 4; e.exp = 64'(exp); e.name = name;
    rdq.push_back(e);
    rd_en_i = 1'b1; rd_addr_i = a;
    step(1);
    rd_en_i = 1'b0;
  endtask

  initial begin
    // reset values
    step(2);
    expect_sig(0, 0, "rst_irq");
    expect_sig(1, 0, "rst_tick");
    expect_sig(2, 0, "rst_time");
    expect_sig(3, 0, "rst_cycles");
    expect_sig(4, 0, "rst_rdata");
    @(negedge clk_i);
    rst_i = 1'b1;

    // default prescaler 9: tick after edge 10, 20; time lags by one edge
    step(20);
    expect_sig(1, 1, "dflt_tick20");
    expect_sig(2, 1, "dflt_time20");
    expect_sig(3, 20, "cycles20");
    step(1);
    expect_sig(1, 0, "dflt_tick21");
    expect_sig(2, 2, "dflt_time21");
    expect_sig(3, 21, "cycles21");
    reg_rd(0, 9, "presc_dflt");
    reg_rd(1, 1, "ctrl_dflt");
    reg_rd(6, 0, "ch0ctrl_dflt");
    reg_rd(2, 0, "pend_dflt");

    // PRESC=3 mid-period: tick exactly 4 clocks after the write edge
    reg_wr(0, 3);
    expect_sig(1, 0, "p3_tick_w");
    step(3);
    expect_sig(1, 0, "p3_tick_w3");
    step(1);
    expect_sig(1, 1, "p3_tick_w4");
    step(1);
    expect_sig(1, 0, "p3_tick_w5");
    reg_rd(0, 3, "presc_rb");

    // PRESC=0: tick every clock
    reg_wr(0, 0);
    expect_sig(1, 0, "p0_tick_w");
    step(1);
    expect_sig(1, 1, "p0_tick_w1");
    step(1);
    expect_sig(1, 1, "p0_tick_w2");

    // CH0 one-shot CMP=5
    reg_wr(1, 0);
    reg_wr(3, 0);
    reg_wr(4, 5);
    reg_wr(6, 1);
    reg_wr(2, 32'hF);
    reg_wr(1, 1);
    step(5);
    expect_sig(2, 4, "os_time4");
    expect_sig(0, 0, "os_irq_pre");
    step(1);
    expect_sig(2, 5, "os_time5");
    expect_sig(0, 1, "os_irq_hit");
    reg_rd(6, 0, "os_chen_clr");
    reg_rd(2, 1, "os_pend");
    reg_wr(2, 1);
    expect_sig(0, 0, "os_w1c");
    for (int i = 0; i < 20; i++) begin
      step(16);
      expect_sig(0, 0, "os_nohit_wrap");
    end

    // CH1 periodic CMP=2 PERIOD=3: hits at 2, 5, 8
    reg_wr(1, 0);
    reg_wr(3, 0);
    reg_wr(8, 2);
    reg_wr(9, 3);
    reg_wr(10, 3);
    reg_wr(2, 32'hF);
    reg_wr(1, 1);
    step(3);
    expect_sig(2, 2, "per_time2");
    expect_sig(0, 4'b0010, "per_hit2");
    reg_wr(2, 2);
    expect_sig(0, 0, "per_clr2");
    step(1);
    expect_sig(0, 0, "per_time4_irq");
    step(1);
    expect_sig(2, 5, "per_time5");
    expect_sig(0, 4'b0010, "per_hit5");
    reg_rd(8, 8, "per_cmp8");
    reg_wr(2, 2);
    expect_sig(0, 0, "per_clr5");
    step(1);
    expect_sig(2, 8, "per_time8");
    expect_sig(0, 4'b0010, "per_hit8");
    reg_rd(8, 11, "per_cmp11");
    reg_rd(10, 3, "per_still_en");

    // periodic across wrap: CMP=254 PERIOD=4 -> hits at 254 then 2
    reg_wr(1, 0);
    reg_wr(3, 250);
    reg_wr(8, 254);
    reg_wr(9, 4);
    reg_wr(10, 3);
    reg_wr(2, 32'hF);
    reg_wr(1, 1);
    step(5);
    expect_sig(2, 254, "wrap_time254");
    expect_sig(0, 4'b0010, "wrap_hit254");
    reg_wr(2, 2);
    expect_sig(0, 0, "wrap_clr");
    step(2);
    expect_sig(2, 1, "wrap_time1");
    expect_sig(0, 0, "wrap_irq1");
    step(1);
    expect_sig(2, 2, "wrap_time2");
    expect_sig(0, 4'b0010, "wrap_hit2");

    // hit and W1C on the same edge: set wins (next hit at 6)
    step(3);
    reg_wr(2, 2);
    expect_sig(2, 6, "race_time6");
    expect_sig(0, 4'b0010, "race_pend_kept");
    reg_rd(8, 10, "race_cmp10");

    // TIME write to 4 with CMP=5: hit on the next tick
    reg_wr(1, 0);
    reg_wr(10, 0);
    reg_wr(2, 32'hF);
    reg_wr(4, 5);
    reg_wr(6, 1);
    reg_wr(3, 0);
    reg_wr(1, 1);
    reg_wr(3, 4);
    expect_sig(2, 4, "tw_time4");
    expect_sig(0, 0, "tw_irq_pre");
    step(1);
    expect_sig(2, 5, "tw_time5");
    expect_sig(0, 1, "tw_hit");

    // same-cycle read and write returns old value; only low bits stored
    rdq.push_back('{sel: 4, exp: 64'd0, name: "rw_same_old"});
    rd_en_i = 1'b1; rd_addr_i = 6'd12;
    wr_en_i = 1'b1; wr_addr_i = 6'd12; wr_data_i = 32'h1AB;
    step(1);
    rd_en_i = 1'b0; wr_en_i = 1'b0;
    reg_rd(12, 32'hAB, "cmp2_lowbits");

    // unmapped, reserved and absent-channel words
    reg_wr(20, 32'h55);
    reg_rd(20, 0, "absent_ch4");
    reg_rd(7, 0, "reserved7");
    reg_rd(63, 0, "unmapped63");

    // asynchronous reset mid-run
    reg_rd(2, 1, "pend_before_rst");
    step(1);
    rst_i = 1'b0;
    #1;
    expect_sig(0, 0, "arst_irq");
    expect_sig(1, 0, "arst_tick");
    expect_sig(2, 0, "arst_time");
    expect_sig(3, 0, "arst_cycles");
    expect_sig(4, 0, "arst_rdata");
    @(negedge clk_i);
    rst_i = 1'b1;
    step(1);
    reg_rd(0, 9, "arst_presc");
    reg_rd(1, 1, "arst_ctrl");
    reg_rd(4, 0, "arst_cmp0");
    reg_rd(2, 0, "arst_pend");

    step(3);
    compare("rdq_drained", 64'(rdq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
